// File: rtl/t05_hist_pkg.sv
// Shared types and constants for the Huffman histogram front end.
package t05_hist_pkg;

  typedef enum logic [3:0] {
    IDLE,
    READY,
    RD_REQ,
    RD_WAIT,
    LATCH,
    CALC,
    WR_REQ,
    WR_WAIT,
    DONE
  } hist_state_e;

  // Request codes presented to the SRAM interface on hist_r_wr
  localparam logic [1:0] HIST_RD  = 2'd0;
  localparam logic [1:0] HIST_WR  = 2'd1;
  localparam logic [1:0] HIST_NOP = 2'd2;

  localparam logic [7:0] DEF_EOF_CHAR = 8'h1A;

endpackage

// File: rtl/t05_histogram.sv
// Histogram builder: one read-modify-write of a 32-bit SRAM count per
// accepted character, finishing once the end-of-file character is counted.
module t05_histogram
  import t05_hist_pkg::*;
#(
  parameter logic [7:0] EOF_CHAR = DEF_EOF_CHAR,
  parameter int         CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  input  logic             sram_init,
  input  logic             busy_o,
  input  logic [CNT_W-1:0] old_char,
  output logic [CNT_W-1:0] histogram,
  output logic [7:0]       histgram_addr,
  output logic [1:0]       hist_r_wr,
  output logic             hist_read_latch,
  output logic [31:0]      total_chars,
  output logic             hist_err,
  output logic             hist_done
);

  hist_state_e state_q, state_d;
  logic        busy_last;
  logic        busy_fall;
  logic        eof_pend;
  logic        take_char;

  // Count increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [31:0] sat_inc_32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign busy_fall = busy_last && !busy_o;
  // A dropped byte (bit 7 set) still completes the handshake but is not counted
  assign take_char = (state_q == READY) && in_valid && !in_char[7];

  // State register and Wishbone busy history
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_last <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_last <= busy_o;
    end
  end

  // Next-state and per-state request outputs
  always_comb begin
    state_d         = state_q;
    in_ready        = 1'b0;
    hist_r_wr       = HIST_NOP;
    hist_read_latch = 1'b0;
    hist_done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && !sram_init) state_d = READY;
      end
      READY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!in_char[7]) state_d = RD_REQ;
        end else if (!en) begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        hist_r_wr = HIST_RD;
        if (!busy_o) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (busy_fall) state_d = LATCH;
      end
      LATCH: begin
        hist_read_latch = 1'b1;
        state_d         = CALC;
      end
      CALC: begin
        state_d = WR_REQ;
      end
      WR_REQ: begin
        hist_r_wr = HIST_WR;
        if (!busy_o) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        // The write must land before leaving, so a falling en only takes
        // effect here, never mid read-modify-write
        if (busy_fall) begin
          if (eof_pend)  state_d = DONE;
          else if (en)   state_d = READY;
          else           state_d = IDLE;
        end
      end
      DONE: begin
        hist_done = 1'b1;
        if (!en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Character capture, running totals, error flag and incremented count
  always_ff @(posedge clk) begin
    if (rst) begin
      histogram     <= '0;
      histgram_addr <= '0;
      total_chars   <= '0;
      hist_err      <= 1'b0;
      eof_pend      <= 1'b0;
    end else begin
      if ((state_q == READY) && in_valid && in_char[7]) hist_err <= 1'b1;
      if (take_char) begin
        histgram_addr <= in_char;
        total_chars   <= sat_inc_32(total_chars);
        eof_pend      <= (in_char == EOF_CHAR);
      end
      if (state_q == CALC) histogram <= sat_inc_cnt(old_char);
    end
  end

endmodule

// File: tb/tb_t05_histogram.sv
// Randomized bench for t05_histogram with an SRAM/Wishbone responder and a
// per-character count reference model.
module tb_t05_histogram;
  import t05_hist_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, sram_init;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        busy_o;
  logic [31:0] old_char;
  logic [31:0] histogram;
  logic [7:0]  histgram_addr;
  logic [1:0]  hist_r_wr;
  logic        hist_read_latch;
  logic [31:0] total_chars;
  logic        hist_err, hist_done;

  t05_histogram dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_char(in_char),
    .in_ready(in_ready), .sram_init(sram_init), .busy_o(busy_o),
    .old_char(old_char), .histogram(histogram), .histgram_addr(histgram_addr),
    .hist_r_wr(hist_r_wr), .hist_read_latch(hist_read_latch),
    .total_chars(total_chars), .hist_err(hist_err), .hist_done(hist_done)
  );

  always #5 clk = ~clk;

  // SRAM + Wishbone responder
  logic [31:0] mem [256];
  logic        model_busy = 1'b0;
  logic        force_busy = 1'b0;
  int          busy_cnt = 0;
  int          busy_lat = 3;
  int          n_rd = 0, n_wr = 0, n_latch = 0;
  logic        clear_mem = 1'b0;
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = 8'd0;
  logic [31:0] pre_val = 32'd0;

  assign busy_o = model_busy | force_busy;

  always @(posedge clk) begin
    if (rst) begin
      model_busy <= 1'b0;
      busy_cnt   <= 0;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) model_busy <= 1'b0;
    end else if (hist_r_wr != HIST_NOP && !busy_o) begin
      model_busy <= 1'b1;
      busy_cnt   <= busy_lat;
      if (hist_r_wr == HIST_WR) begin
        mem[histgram_addr] <= histogram;
        n_wr <= n_wr + 1;
      end else begin
        n_rd <= n_rd + 1;
      end
    end
    if (hist_read_latch) begin
      old_char <= mem[histgram_addr];
      n_latch  <= n_latch + 1;
    end
    if (clear_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      n_rd <= 0; n_wr <= 0; n_latch <= 0;
    end
    if (pre_we) mem[pre_addr] <= pre_val;
  end

  // Reference model: expected counts per character
  logic [31:0] exp_cnt [256];
  logic [31:0] exp_total;
  logic        exp_err;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ref_byte(input logic [7:0] c);
    if (c[7]) exp_err = 1'b1;
    else begin
      if (exp_cnt[c] != 32'hFFFF_FFFF) exp_cnt[c] = exp_cnt[c] + 32'd1;
      exp_total = exp_total + 32'd1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_char = 8'd0;
    force_busy = 1'b0; sram_init = 1'b0; clear_mem = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; clear_mem = 1'b0;
    for (int i = 0; i < 256; i++) exp_cnt[i] = 32'd0;
    exp_total = 32'd0;
    exp_err = 1'b0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_val = v;
    @(negedge clk);
    pre_we = 1'b0;
    exp_cnt[a] = v;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] c);
    @(negedge clk);
    wait_ready("send_ready");
    in_valid = 1'b1; in_char = c;
    @(negedge clk);
    in_valid = 1'b0;
    ref_byte(c);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!hist_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val("hist_done", {31'd0, hist_done}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [7:0] c;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_char = 8'd0; sram_init = 1'b1;

    // Reset values and sram_init gating
    repeat (2) @(negedge clk);
    check_val("rst_r_wr", {30'd0, hist_r_wr}, {30'd0, HIST_NOP});
    check_val("rst_ready", {31'd0, in_ready}, 32'd0);
    check_val("rst_hist", histogram, 32'd0);
    check_val("rst_addr", {24'd0, histgram_addr}, 32'd0);
    check_val("rst_total", total_chars, 32'd0);
    check_val("rst_err", {31'd0, hist_err}, 32'd0);
    check_val("rst_done", {31'd0, hist_done}, 32'd0);
    check_val("rst_latch", {31'd0, hist_read_latch}, 32'd0);
    rst = 1'b0; en = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (in_ready) bad++;
    end
    check_val("init_hold_ready", bad, 0);
    sram_init = 1'b0;
    repeat (2) @(negedge clk);
    check_val("init_release_ready", {31'd0, in_ready}, 32'd1);

    // a, b, a, EOF
    do_reset();
    en = 1'b1; busy_lat = 3;
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h61); send_byte(8'h1A);
    wait_done();
    check_val("mem61", mem[8'h61], 32'd2);
    check_val("mem62", mem[8'h62], 32'd1);
    check_val("mem1A", mem[8'h1A], 32'd1);
    check_val("total4", total_chars, 32'd4);
    @(negedge clk);
    check_val("done_ready", {31'd0, in_ready}, 32'd0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check_val("done_clear", {31'd0, hist_done}, 32'd0);

    // Saturation of a full count
    do_reset();
    en = 1'b1;
    preload(8'h41, 32'hFFFF_FFFF);
    send_byte(8'h41);
    wait_ready("sat_ready");
    check_val("sat_mem", mem[8'h41], 32'hFFFF_FFFF);
    check_val("sat_hist", histogram, 32'hFFFF_FFFF);
    check_val("sat_total", total_chars, 32'd1);

    // High-bit byte dropped without SRAM traffic
    do_reset();
    en = 1'b1;
    send_byte(8'hC3); send_byte(8'h7A);
    wait_ready("err_ready");
    check_val("err_flag", {31'd0, hist_err}, 32'd1);
    check_val("err_total", total_chars, 32'd1);
    check_val("err_mem7A", mem[8'h7A], 32'd1);
    check_val("err_reads", n_rd, 1);
    check_val("err_writes", n_wr, 1);

    // Read request held off by a long busy
    do_reset();
    en = 1'b1;
    @(negedge clk);
    wait_ready("busy_ready");
    force_busy = 1'b1;
    send_byte(8'h71);
    bad = 0;
    repeat (20) begin
      if (hist_r_wr != HIST_RD || hist_read_latch) bad++;
      @(negedge clk);
    end
    check_val("busy_hold_rd", bad, 0);
    force_busy = 1'b0;
    wait_ready("busy_after");
    check_val("busy_latch_cnt", n_latch, 1);
    check_val("busy_mem71", mem[8'h71], 32'd1);

    // Reset while waiting for the write to finish
    do_reset();
    en = 1'b1; busy_lat = 4;
    send_byte(8'h72);
    bad = 0;
    while (hist_r_wr != HIST_WR && bad < 200) begin
      @(negedge clk);
      bad++;
    end
    check_val("wr_seen", {30'd0, hist_r_wr}, {30'd0, HIST_WR});
    @(negedge clk);
    check_val("wr_wait_nop", {30'd0, hist_r_wr}, {30'd0, HIST_NOP});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mid_rst_r_wr", {30'd0, hist_r_wr}, {30'd0, HIST_NOP});
    check_val("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check_val("mid_rst_total", total_chars, 32'd0);
    check_val("mid_rst_done", {31'd0, hist_done}, 32'd0);

    // Randomized stream against the reference counts
    do_reset();
    en = 1'b1;
    preload(8'h61, 32'hFFFF_FFFE);
    preload(8'h63, 32'd1000);
    for (int k = 0; k < 60; k++) begin
      busy_lat = $urandom_range(1, 5);
      if ($urandom_range(0, 9) == 0) c = 8'h80 | 8'($urandom_range(0, 127));
      else c = 8'h61 + 8'($urandom_range(0, 7));
      send_byte(c);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    send_byte(8'h1A);
    wait_done();
    for (int i = 0; i < 128; i++) check_val($sformatf("rnd_mem%0h", i), mem[i], exp_cnt[i]);
    check_val("rnd_total", total_chars, exp_total);
    check_val("rnd_err", {31'd0, hist_err}, {31'd0, exp_err});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
